// File: rtl/spi_bridge_pkg.sv
// Shared constants and types for the SPI slot register bank and its arbiter.
package spi_bridge_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;

    localparam logic [7:0] TX_BASE   = 8'h00;
    localparam logic [7:0] RX_BASE   = 8'h01;
    localparam logic [7:0] STAT_BASE = 8'h10;
    localparam logic [7:0] ERR_CLR   = 8'h1F;
    localparam logic [7:0] ADDR_END  = 8'h20;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {TX_IDLE, TX_OFFER} tx_state_e;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module spi_rr_arbiter
    import spi_bridge_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] req,
    input  logic [SLOT_W-1:0]    ptr,
    output logic [SLOT_W-1:0]    grant,
    output logic                 any_grant
);

    logic [SLOT_W-1:0] idx;

    // Walk from the farthest offset down so the nearest request wins last.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            idx = ptr + SLOT_W'(k);
            if (req[idx]) begin
                grant     = idx;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_slot_regbank.sv
// TX/RX slot register bank between the AXI4-Lite slave and the SPI engine.
// Optional irq output enabled by defining SPI_REGBANK_IRQ_EN.
module spi_slot_regbank
    import spi_bridge_pkg::TX_BASE, spi_bridge_pkg::RX_BASE, spi_bridge_pkg::STAT_BASE,
           spi_bridge_pkg::ERR_CLR, spi_bridge_pkg::ADDR_END, spi_bridge_pkg::RESP_OKAY,
           spi_bridge_pkg::RESP_SLVERR, spi_bridge_pkg::SLOT_W, spi_bridge_pkg::tx_state_e,
           spi_bridge_pkg::TX_IDLE, spi_bridge_pkg::TX_OFFER;
#(
    parameter int NUM_SLOTS = 8,
    parameter int DATA_W    = 32
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic [7:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              wrUpdateDone,
    input  logic [7:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              getTxRegStat,
    output logic              getRxRegStat,
    output logic [1:0]        getBRESP,
    output logic [1:0]        getRRESP,
    output logic [DATA_W-1:0] spi_tx_data,
    output logic [SLOT_W-1:0] spi_tx_slot,
    output logic              spi_tx_valid,
    input  logic              spi_tx_ready,
    input  logic [DATA_W-1:0] spi_rx_data,
    input  logic [SLOT_W-1:0] spi_rx_slot,
    input  logic              spi_rx_valid,
    output logic              err_tx_drop,
    output logic              err_rx_ovr
`ifdef SPI_REGBANK_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic [NUM_SLOTS-1:0][DATA_W-1:0] tx_slot, rx_slot;
    logic [NUM_SLOTS-1:0] tx_full, rx_full;
    logic [SLOT_W-1:0]    rr_ptr, grant, wr_slot, rd_slot;
    logic                 any_grant, wr_en_q, wr_pulse;
    logic                 wr_tx, wr_rxclr, wr_errclr;
    logic                 handshake, tx_load, tx_drop, offer_take;
    tx_state_e            state, state_nxt;

    logic unused;
    assign unused = wrUpdateDone;

    // wr_en is held for the whole AXI write; act only on its first cycle.
    assign wr_pulse  = wr_en & ~wr_en_q;
    assign wr_slot   = wr_addr[3:1];
    assign wr_tx     = wr_pulse && ((wr_addr & 8'hF1) == TX_BASE);
    assign wr_rxclr  = wr_pulse && ((wr_addr & 8'hF1) == RX_BASE);
    assign wr_errclr = wr_pulse && (wr_addr == ERR_CLR);

    assign spi_tx_valid = (state == TX_OFFER);
    assign handshake    = spi_tx_valid & spi_tx_ready;

    // A slot being handed off this cycle counts as empty, so a coincident write reloads it.
    assign tx_load = wr_tx && (!tx_full[wr_slot] || (handshake && spi_tx_slot == wr_slot));
    assign tx_drop = wr_tx && !tx_load;

    assign rd_slot      = rd_addr[3:1];
    assign rd_data      = rx_slot[rd_slot];
    assign getTxRegStat = tx_full[rd_slot];
    assign getRxRegStat = rx_full[rd_slot];
    assign getBRESP     = (&tx_full) ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        if (rd_addr >= ADDR_END)       getRRESP = RESP_SLVERR;
        else if (rd_addr >= STAT_BASE) getRRESP = RESP_OKAY;
        else if (rd_addr[0])           getRRESP = RESP_OKAY;
        else                           getRRESP = RESP_SLVERR;
    end

    spi_rr_arbiter u_arb (
        .req       (tx_full),
        .ptr       (rr_ptr),
        .grant     (grant),
        .any_grant (any_grant)
    );

    always_comb begin
        state_nxt  = state;
        offer_take = 1'b0;
        case (state)
            TX_IDLE: if (any_grant) begin
                state_nxt  = TX_OFFER;
                offer_take = 1'b1;
            end
            TX_OFFER: if (spi_tx_ready) state_nxt = TX_IDLE;
            default:  state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state       <= TX_IDLE;
            wr_en_q     <= 1'b0;
            tx_slot     <= '0;
            rx_slot     <= '0;
            tx_full     <= '0;
            rx_full     <= '0;
            rr_ptr      <= '0;
            spi_tx_data <= '0;
            spi_tx_slot <= '0;
            err_tx_drop <= 1'b0;
            err_rx_ovr  <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_en_q <= wr_en;
            if (offer_take) begin
                spi_tx_data <= tx_slot[grant];
                spi_tx_slot <= grant;
            end
            if (handshake) begin
                tx_full[spi_tx_slot] <= 1'b0;
                rr_ptr               <= spi_tx_slot + SLOT_W'(1);
            end
            if (tx_load) begin
                tx_slot[wr_slot] <= wr_data;
                tx_full[wr_slot] <= 1'b1;
            end
            if (wr_errclr) begin
                err_tx_drop <= 1'b0;
                err_rx_ovr  <= 1'b0;
            end
            if (tx_drop) err_tx_drop <= 1'b1;
            if (wr_rxclr) rx_full[wr_slot] <= 1'b0;
            // Incoming RX beats a same-cycle clear of the same slot.
            if (spi_rx_valid) begin
                rx_slot[spi_rx_slot] <= spi_rx_data;
                rx_full[spi_rx_slot] <= 1'b1;
                if (rx_full[spi_rx_slot]) err_rx_ovr <= 1'b1;
            end
        end
    end

`ifdef SPI_REGBANK_IRQ_EN
    always_ff @(posedge ACLK) begin
        if (!ARESETN) irq <= 1'b0;
        else          irq <= (|rx_full) | err_tx_drop | err_rx_ovr;
    end
`endif

endmodule

// File: doc/spi_slot_regbank.md
Name: spi_slot_regbank

Overview:
- Register bank that sits directly downstream of the AXI4-Lite slave front end and upstream of the SPI master engine.
- Consumes the slave's registered write port (wr_addr/wr_data/wr_en) and serves its read side (rd_addr -> rd_data, TX/RX status, BRESP/RRESP codes).
- Holds 8 TX slots and 8 RX slots.
- A round-robin scheduler issues full TX slots to the SPI engine over a valid/ready handshake; received SPI words land in RX slots.

Parameters:
- NUM_SLOTS, 8, number of TX/RX slot pairs (address map fixed for 8; other values unsupported).
- DATA_W, 32, slot data width.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  synchronous active-low reset
- wr_addr  in  8  write address from AXI slave
- wr_data  in  32  byte-masked write data
- wr_en  in  1  write strobe, level; held high until B handshake
- wrUpdateDone  in  1  unused; reserved
- rd_addr  in  8  read address, stable from AR handshake
- rd_data  out  32  RX slot data for rd_addr
- getTxRegStat  out  1  tx_full of slot rd_addr[3:1]
- getRxRegStat  out  1  rx_full of slot rd_addr[3:1]
- getBRESP  out  2  write response code
- getRRESP  out  2  read response code
- spi_tx_data  out  32  word to SPI engine
- spi_tx_slot  out  3  slot index of spi_tx_data
- spi_tx_valid  out  1  offer valid
- spi_tx_ready  in  1  SPI engine accepts
- spi_rx_data  in  32  received word
- spi_rx_slot  in  3  destination RX slot
- spi_rx_valid  in  1  one-cycle RX strobe, always accepted
- err_tx_drop  out  1  sticky: write to full TX slot dropped
- err_rx_ovr  out  1  sticky: RX into full slot overwrote

Behaviour:
- Clock ACLK. Reset synchronous on ARESETN==0: all slots, tx_full, rx_full, rr_ptr, spi_tx_valid, spi_tx_data, spi_tx_slot and sticky errors go to 0.
- Reset mid-transfer drops the offered word with no handshake.
- Write detection:
  - wr_en is a level, so the bank acts only on its rising edge: wr_pulse = wr_en & ~wr_en_q.
  - Exactly one action per AXI write.
- Address map, slot i = addr[3:1]:
  - 0x00+2i: load TX slot i and set tx_full[i]. If tx_full[i] is already set: drop the write and set err_tx_drop.
  - 0x01+2i: a write of any data clears rx_full[i].
  - 0x1F: a write clears both sticky errors.
  - Other writes are ignored.
- Read data (combinational from rd_addr):
  - rd_data = rx_slot[rd_addr[3:1]].
  - getTxRegStat and getRxRegStat are combinational from rd_addr[3:1].
- getRRESP (combinational):
  - 2'b00 for odd addresses 0x01-0x0F and for 0x10-0x1F.
  - 2'b10 (SLVERR) for even 0x00-0x0E (write-only) and for addresses >= 0x20.
- getBRESP:
  - 2'b10 when all 8 tx_full bits are set; 2'b00 otherwise.
  - The slave suppresses wr_en on SLVERR, so no write action occurs.
- TX scheduler:
  - Output stage states are IDLE (spi_tx_valid=0) and OFFER (spi_tx_valid=1).
  - IDLE: if any tx_full slot is not already offered, pick the first full slot searching from rr_ptr upward, mod 8. Next cycle: spi_tx_valid=1 and data/slot registered (1-cycle latency from tx_full set).
  - OFFER: data and slot are held stable until spi_tx_ready.
  - On handshake: clear tx_full[slot], rr_ptr <= slot+1 (wraps 7 -> 0), return to IDLE. No back-to-back offer; minimum 2 cycles per word.
  - A write to the offered slot while in OFFER is dropped with err_tx_drop, because the slot is still full.
  - Write to the offered slot in the same cycle as its handshake: the write wins, the slot is reloaded and tx_full stays 1.
- RX path:
  - spi_rx_valid writes rx_slot[spi_rx_slot] and sets rx_full.
  - If rx_full was already 1: overwrite the slot and set err_rx_ovr.
  - RX clear (write to 0x01+2i) in the same cycle as spi_rx_valid to the same slot: RX wins, so rx_full=1.

Optional Feature:
- SPI_REGBANK_IRQ_EN: adds output port irq, registered, = |rx_full | err_tx_drop | err_rx_ovr, with reset value 0.
- Without the macro, the port and its logic are absent.

Decomposition:
- Shared package/include spi_bridge_pkg:
  - address constants: TX_BASE 0x00, RX_BASE 0x01, STAT_BASE 0x10, ERR_CLR 0x1F
  - RESP_OKAY 2'b00, RESP_SLVERR 2'b10
  - NUM_SLOTS
- Sub-module spi_rr_arbiter: 8-bit request, 3-bit pointer -> grant index + any_grant, purely combinational.

Test Plan:
- Write 0x00 = 0xA5A5_0001 (wr_en held 3 cycles) -> tx_full[0] set once; spi_tx_valid=1 with data 0xA5A5_0001, slot 0 next cycle; held until spi_tx_ready; tx_full[0]=0 after the handshake.
- Writes to slots 2, 5, 7 with spi_tx_ready=1 and rr_ptr=6 -> issue order 7, 2, 5.
- Write 0x04 twice without draining -> second write dropped, err_tx_drop=1; write 0x1F -> err_tx_drop=0.
- spi_rx_valid slot 3 data 0xDEAD_BEEF, rd_addr=0x07 -> rd_data=0xDEAD_BEEF, getRRESP=00; rd_addr=0x17 -> getRxRegStat=1; second RX to slot 3 -> err_rx_ovr=1.
- Fill all 8 TX slots with spi_tx_ready=0 -> getBRESP=2'b10; rd_addr=0x02 -> getRRESP=2'b10; rd_addr=0x40 -> getRRESP=2'b10.
- ARESETN low during OFFER -> spi_tx_valid=0, all status 0 on the next cycle.
